bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Shares one memory bus master between the instruction-fetch stage and the
// MEM (load/store) stage. Grants are fixed-priority (MEM first) and
// non-preemptive. A wait counter aborts a transaction that the slave never
// acknowledges. A pipeline flush cancels delivery of a fetch that is in
// flight, but the bus cycle itself still runs to completion.
//
// Ports
//   clk                     single clock, rising edge
//   rst                     asynchronous, active-low reset
//   if_req / if_addr        fetch request (level, held until if_ack) and address
//   if_rdata / if_ack       fetched word and its one-cycle completion pulse
//   flush                   cancels delivery of the fetch in progress
//   mem_req                 load/store request (level, held until mem_ack)
//   mem_we/sel/addr/wdata   load/store attributes
//   mem_rdata / mem_ack     load data (0 for stores) and one-cycle completion pulse
//   bus_cyc/stb/we/sel/addr/wdata  registered bus master outputs
//   bus_rdata / bus_ack     slave read data and completion
//   bus_err                 one-cycle pulse alongside the ack of a timed-out cycle
//   stall_req               combinational stall request to the control unit
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        flush,
  // load/store port
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  // shared bus master
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  // pipeline control
  output logic        stall_req
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  // The counter holds the number of busy cycles already spent without an
  // ack, so the cycle in which it equals TIMEOUT-1 is the last one allowed.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  wait_cnt_reg;
  logic        ready_reg;

  logic        bus_cyc_reg;
  logic        bus_stb_reg;
  logic        bus_we_reg;
  logic [3:0]  bus_sel_reg;
  logic [31:0] bus_addr_reg;
  logic [31:0] bus_wdata_reg;
  logic        bus_err_reg;

  logic        if_ack_reg;
  logic [31:0] if_rdata_reg;
  logic        mem_ack_reg;
  logic [31:0] mem_rdata_reg;

  logic        timeout_hit;
  logic        mem_go;
  logic        if_go;
  logic [31:0] mem_load_data;

  assign timeout_hit = (wait_cnt_reg == WAIT_LAST);

  // A requester keeps its request high during its own ack cycle; masking
  // with the registered ack stops that stale level from being re-granted
  // and leaves exactly one IDLE cycle between transactions.
  // ready_reg delays the first grant to the second edge after reset release.
  assign mem_go = ready_reg & mem_req & ~mem_ack_reg;
  assign if_go  = ready_reg & if_req  & ~if_ack_reg;

  // Stores return zero; bus_we_reg still holds the granted attribute.
  assign mem_load_data = bus_we_reg ? 32'h0 : bus_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 8'd0;
      ready_reg     <= 1'b0;
      bus_cyc_reg   <= 1'b0;
      bus_stb_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_sel_reg   <= 4'h0;
      bus_addr_reg  <= 32'h0;
      bus_wdata_reg <= 32'h0;
      bus_err_reg   <= 1'b0;
      if_ack_reg    <= 1'b0;
      if_rdata_reg  <= 32'h0;
      mem_ack_reg   <= 1'b0;
      mem_rdata_reg <= 32'h0;
    end else begin
      ready_reg   <= 1'b1;
      // completion strobes are single-cycle by default
      if_ack_reg  <= 1'b0;
      mem_ack_reg <= 1'b0;
      bus_err_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          wait_cnt_reg <= 8'd0;
          if (mem_go) begin
            state_reg     <= MEM_BUSY;
            bus_cyc_reg   <= 1'b1;
            bus_stb_reg   <= 1'b1;
            bus_we_reg    <= mem_we;
            bus_sel_reg   <= mem_sel;
            bus_addr_reg  <= mem_addr;
            bus_wdata_reg <= mem_wdata;
          end else if (if_go) begin
            state_reg     <= IF_BUSY;
            bus_cyc_reg   <= 1'b1;
            bus_stb_reg   <= 1'b1;
            bus_we_reg    <= 1'b0;
            bus_sel_reg   <= 4'hF;
            bus_addr_reg  <= if_addr;
            bus_wdata_reg <= 32'h0;
          end
        end

        MEM_BUSY: begin
          if (bus_ack) begin
            state_reg     <= IDLE;
            bus_cyc_reg   <= 1'b0;
            bus_stb_reg   <= 1'b0;
            mem_ack_reg   <= 1'b1;
            mem_rdata_reg <= mem_load_data;
          end else if (timeout_hit) begin
            state_reg     <= IDLE;
            bus_cyc_reg   <= 1'b0;
            bus_stb_reg   <= 1'b0;
            mem_ack_reg   <= 1'b1;
            mem_rdata_reg <= 32'h0;
            bus_err_reg   <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end

        IF_BUSY: begin
          if (bus_ack || timeout_hit) begin
            state_reg   <= IDLE;
            bus_cyc_reg <= 1'b0;
            bus_stb_reg <= 1'b0;
            // A flush landing on the completing cycle swallows the result
            // silently, including any timeout indication.
            if (!flush) begin
              if_ack_reg   <= 1'b1;
              if_rdata_reg <= bus_ack ? bus_rdata : 32'h0;
              bus_err_reg  <= ~bus_ack;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
            // The slave has already seen the strobe, so the cycle cannot be
            // withdrawn; finish it quietly in DRAIN.
            if (flush) begin
              state_reg <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (bus_ack || timeout_hit) begin
            state_reg   <= IDLE;
            bus_cyc_reg <= 1'b0;
            bus_stb_reg <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end

        default: begin
          state_reg   <= IDLE;
          bus_cyc_reg <= 1'b0;
          bus_stb_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus_cyc   = bus_cyc_reg;
  assign bus_stb   = bus_stb_reg;
  assign bus_we    = bus_we_reg;
  assign bus_sel   = bus_sel_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign bus_err   = bus_err_reg;
  assign if_ack    = if_ack_reg;
  assign if_rdata  = if_rdata_reg;
  assign mem_ack   = mem_ack_reg;
  assign mem_rdata = mem_rdata_reg;

  // A flushed fetch no longer needs to hold the pipeline.
  assign stall_req = (mem_req & ~mem_ack_reg) | (if_req & ~if_ack_reg & ~flush);

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Table of single transactions, hand-written multi-cycle sequences for the
// latency / contention / timeout / flush / reset cases, then a randomized
// phase checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        flush = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_sel = 4'h0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic        bus_err;
  logic        stall_req;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .bus_cyc   (bus_cyc),
    .bus_stb   (bus_stb),
    .bus_we    (bus_we),
    .bus_sel   (bus_sel),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err),
    .stall_req (stall_req)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        mem_req;
    logic        if_req;
    logic        mem_we;
    logic        flush;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] if_addr;
    logic [31:0] rdata;
    logic        e_mem;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_addr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [5];
  vec_t v;

  int lat;
  int mem_at;
  int if_at;
  int n_grants;
  logic [31:0] grant_addr [2];
  logic prev_stb;

  // random-phase state
  bit          m_busy;
  bit          m_mem;
  bit          m_store;
  int          m_cnt;
  logic        e_mem_ack;
  logic        e_if_ack;
  logic        e_err;
  logic [31:0] e_mem_rd;
  logic [31:0] e_if_rd;
  logic        e_we;
  logic [3:0]  e_sel;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic        nm;
  logic        ni;
  logic        ne;
  bit          s_active;
  int          s_wait;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    #2 rst = 1'b0;
    #1;
    chk1("rst_cyc_async", bus_cyc, 1'b0);
    chk1("rst_stb_async", bus_stb, 1'b0);
    tick();
    tick();
    chk1("rst_we", bus_we, 1'b0);
    chk32("rst_sel", 32'(bus_sel), 32'h0);
    chk32("rst_addr", bus_addr, 32'h0);
    chk32("rst_wdata", bus_wdata, 32'h0);
    chk1("rst_mem_ack", mem_ack, 1'b0);
    chk1("rst_if_ack", if_ack, 1'b0);
    chk1("rst_err", bus_err, 1'b0);
    chk32("rst_mem_rdata", mem_rdata, 32'h0);
    chk32("rst_if_rdata", if_rdata, 32'h0);

    // release between edges with a request already waiting
    rst = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h40;
    tick();
    chk1("no_grant_first_edge", bus_cyc, 1'b0);
    tick();
    chk1("grant_second_edge", bus_cyc, 1'b1);
    bus_ack = 1'b1; bus_rdata = 32'h55;
    tick();
    chk1("post_rst_ack", mem_ack, 1'b1);
    chk32("post_rst_rdata", mem_rdata, 32'h55);
    mem_req = 1'b0; bus_ack = 1'b0;
    tick();
    chk1("ack_one_cycle", mem_ack, 1'b0);
    chk32("rdata_hold", mem_rdata, 32'h55);

    // ---------------- table of single transactions ----------------
    //            mreq  ireq  we    fl    sel    maddr         mwdata        iaddr         rdata          e_mem e_we  e_sel  e_addr        e_rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF,  32'h0000_1000, 32'h0,        32'h0,        32'hCAFE_F00D, 1'b1, 1'b0, 4'hF,  32'h0000_1000, 32'hCAFE_F00D};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0,  32'h0,         32'h0,        32'h0000_2000, 32'h0000_0013, 1'b0, 1'b0, 4'hF,  32'h0000_2000, 32'h0000_0013};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h3,  32'h0000_3000, 32'h0000_1234, 32'h0000_2004, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'h3,  32'h0000_3000, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hC,  32'h0000_0044, 32'h0000_9999, 32'h0000_0055, 32'h0000_0077, 1'b1, 1'b0, 4'hC,  32'h0000_0044, 32'h0000_0077};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0,  32'h0,         32'h0,        32'h0000_6000, 32'h0000_0066, 1'b0, 1'b0, 4'hF,  32'h0000_6000, 32'h0000_0066};

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      mem_req = v.mem_req; if_req = v.if_req; mem_we = v.mem_we; flush = v.flush;
      mem_sel = v.mem_sel; mem_addr = v.mem_addr; mem_wdata = v.mem_wdata;
      if_addr = v.if_addr; bus_ack = 1'b0;
      tick();
      chk1($sformatf("v%0d_cyc", i), bus_cyc, 1'b1);
      chk1($sformatf("v%0d_we", i), bus_we, v.e_we);
      chk32($sformatf("v%0d_sel", i), 32'(bus_sel), 32'(v.e_sel));
      chk32($sformatf("v%0d_addr", i), bus_addr, v.e_addr);
      if (v.e_mem) chk32($sformatf("v%0d_wdata", i), bus_wdata, v.mem_wdata);
      flush = 1'b0; bus_ack = 1'b1; bus_rdata = v.rdata;
      tick();
      chk1($sformatf("v%0d_mem_ack", i), mem_ack, v.e_mem);
      chk1($sformatf("v%0d_if_ack", i), if_ack, ~v.e_mem);
      if (v.e_mem) chk32($sformatf("v%0d_mem_rdata", i), mem_rdata, v.e_rdata);
      else         chk32($sformatf("v%0d_if_rdata", i), if_rdata, v.e_rdata);
      chk1($sformatf("v%0d_cyc_drop", i), bus_cyc, 1'b0);
      chk1($sformatf("v%0d_err", i), bus_err, 1'b0);
      mem_req = 1'b0; if_req = 1'b0; bus_ack = 1'b0;
      tick();
    end

    // ---------------- single load, 3 wait cycles ----------------
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h100;
    bus_ack = 1'b0; bus_rdata = 32'hDEADBEEF;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) chk32("load_addr", bus_addr, 32'h100);
      if (mem_ack) begin
        lat = c;
        chk32("load_rdata", mem_rdata, 32'hDEADBEEF);
        chk1("load_cyc_drop", bus_cyc, 1'b0);
        break;
      end
      bus_ack = (c == 4);
    end
    chk32("load_latency", 32'(lat), 32'd5);
    mem_req = 1'b0; bus_ack = 1'b0;
    tick();

    // ---------------- contention, zero-wait slave ----------------
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h200; bus_rdata = 32'hA5A5A5A5; bus_ack = 1'b0;
    #1;
    chk1("cont_stall_c0", stall_req, 1'b1);
    mem_at = -1; if_at = -1; n_grants = 0; prev_stb = 1'b0;
    grant_addr[0] = 32'h0; grant_addr[1] = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus_stb && !prev_stb) begin
        if (n_grants < 2) grant_addr[n_grants] = bus_addr;
        n_grants++;
      end
      prev_stb = bus_stb;
      if (c == 2) chk1("cont_idle_gap", bus_cyc, 1'b0);
      if (mem_ack) begin mem_at = c; mem_req = 1'b0; end
      if (if_ack) if_at = c;
      bus_ack = bus_stb;
      #1;
      if (if_at < 0) chk1($sformatf("cont_stall_c%0d", c), stall_req, 1'b1);
      else begin
        chk1("cont_stall_at_ack", stall_req, 1'b0);
        break;
      end
    end
    chk32("cont_mem_ack_cycle", 32'(mem_at), 32'd2);
    chk32("cont_if_ack_cycle", 32'(if_at), 32'd4);
    chk32("cont_first_addr", grant_addr[0], 32'h300);
    chk32("cont_second_addr", grant_addr[1], 32'h200);
    chk32("cont_if_rdata", if_rdata, 32'hA5A5A5A5);
    if_req = 1'b0; bus_ack = 1'b0;
    tick();

    // ---------------- timeout, slave never acks ----------------
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h500; bus_ack = 1'b0;
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 4) chk1("to_still_busy", bus_cyc, 1'b1);
      if (mem_ack) begin
        lat = c;
        chk1("to_err", bus_err, 1'b1);
        chk32("to_rdata", mem_rdata, 32'h0);
        chk1("to_cyc_drop", bus_cyc, 1'b0);
        break;
      end
    end
    chk32("to_latency", 32'(lat), 32'd5);
    mem_req = 1'b0;
    tick();
    chk1("to_err_one_cycle", bus_err, 1'b0);

    // ---------------- flush one cycle into a fetch ----------------
    if_req = 1'b1; if_addr = 32'h600; bus_rdata = 32'h11111111; bus_ack = 1'b0;
    tick();
    chk1("fl_grant", bus_cyc, 1'b1);
    flush = 1'b1;
    #1;
    chk1("fl_stall_masked", stall_req, 1'b0);
    tick();
    flush = 1'b0; if_req = 1'b0;
    chk1("fl_drain_cyc", bus_cyc, 1'b1);
    chk32("fl_drain_addr", bus_addr, 32'h600);
    chk1("fl_no_ack_c2", if_ack, 1'b0);
    tick();
    chk1("fl_drain_cyc_c3", bus_cyc, 1'b1);
    chk1("fl_no_ack_c3", if_ack, 1'b0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk1("fl_cyc_drop", bus_cyc, 1'b0);
    chk1("fl_no_ack_c4", if_ack, 1'b0);
    chk1("fl_no_err", bus_err, 1'b0);
    chk32("fl_rdata_kept", if_rdata, 32'hA5A5A5A5);
    tick();
    chk1("fl_idle_c5", bus_cyc, 1'b0);
    chk1("fl_no_ack_c5", if_ack, 1'b0);

    // ---------------- flush coincident with bus_ack ----------------
    if_req = 1'b1; if_addr = 32'h700;
    tick();
    flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h22;
    tick();
    chk1("flc_no_ack", if_ack, 1'b0);
    chk1("flc_cyc_drop", bus_cyc, 1'b0);
    chk1("flc_no_err", bus_err, 1'b0);
    chk32("flc_rdata_kept", if_rdata, 32'hA5A5A5A5);
    flush = 1'b0; bus_ack = 1'b0; if_req = 1'b0;
    tick();

    // ---------------- reset in the middle of MEM_BUSY ----------------
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h800;
    tick();
    chk1("rm_busy", bus_cyc, 1'b1);
    tick();
    #2 rst = 1'b0;
    #1;
    chk1("rm_cyc_async", bus_cyc, 1'b0);
    chk1("rm_stb_async", bus_stb, 1'b0);
    chk32("rm_rdata_cleared", mem_rdata, 32'h0);
    mem_req = 1'b0; bus_ack = 1'b1;
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1($sformatf("rm_no_ack_%0d", c), mem_ack, 1'b0);
    end
    bus_ack = 1'b0;
    tick();

    // ---------------- randomized phase vs reference model ----------------
    m_busy = 1'b0; m_mem = 1'b0; m_store = 1'b0; m_cnt = 0;
    e_mem_ack = 1'b0; e_if_ack = 1'b0; e_err = 1'b0;
    e_mem_rd = 32'h0; e_if_rd = 32'h0;
    e_we = 1'b0; e_sel = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    s_active = 1'b0; s_wait = 0;
    for (int n = 0; n < 1500; n++) begin
      // predict the effect of the coming edge from this cycle's inputs
      nm = 1'b0; ni = 1'b0; ne = 1'b0;
      if (!m_busy) begin
        if (mem_req && !e_mem_ack) begin
          m_busy = 1'b1; m_mem = 1'b1; m_store = mem_we; m_cnt = 0;
          e_we = mem_we; e_sel = mem_sel; e_addr = mem_addr; e_wdata = mem_wdata;
        end else if (if_req && !e_if_ack) begin
          m_busy = 1'b1; m_mem = 1'b0; m_store = 1'b0; m_cnt = 0;
          e_we = 1'b0; e_sel = 4'hF; e_addr = if_addr;
        end
      end else begin
        m_cnt++;
        if (bus_ack || m_cnt == TO) begin
          m_busy = 1'b0;
          ne = ~bus_ack;
          if (m_mem) begin
            nm = 1'b1;
            e_mem_rd = (bus_ack && !m_store) ? bus_rdata : 32'h0;
          end else begin
            ni = 1'b1;
            e_if_rd = bus_ack ? bus_rdata : 32'h0;
          end
        end
      end
      e_mem_ack = nm; e_if_ack = ni; e_err = ne;

      tick();
      chk1("r_cyc", bus_cyc, m_busy);
      chk1("r_stb", bus_stb, m_busy);
      chk1("r_mem_ack", mem_ack, e_mem_ack);
      chk1("r_if_ack", if_ack, e_if_ack);
      chk1("r_err", bus_err, e_err);
      chk32("r_mem_rdata", mem_rdata, e_mem_rd);
      chk32("r_if_rdata", if_rdata, e_if_rd);
      if (m_busy) begin
        chk32("r_addr", bus_addr, e_addr);
        chk1("r_we", bus_we, e_we);
        chk32("r_sel", 32'(bus_sel), 32'(e_sel));
        if (m_mem) chk32("r_wdata", bus_wdata, e_wdata);
      end

      // requester agents: hold until ack, then drop or reissue
      if ((mem_req && mem_ack && ($urandom_range(1) == 1)) || (!mem_req && ($urandom_range(2) == 0))) begin
        mem_req = 1'b1; mem_we = 1'($urandom_range(1)); mem_sel = 4'($urandom);
        mem_addr = $urandom; mem_wdata = $urandom;
      end else if (mem_req && mem_ack) begin
        mem_req = 1'b0;
      end
      if ((if_req && if_ack && ($urandom_range(1) == 1)) || (!if_req && ($urandom_range(2) == 0))) begin
        if_req = 1'b1; if_addr = $urandom;
      end else if (if_req && if_ack) begin
        if_req = 1'b0;
      end

      // slave: random 0..5 wait cycles per strobe (4 or more times out)
      if (bus_stb) begin
        if (!s_active) begin
          s_active = 1'b1;
          s_wait = $urandom_range(0, 5);
        end else if (s_wait > 0) begin
          s_wait--;
        end
        bus_ack = (s_wait == 0);
      end else begin
        s_active = 1'b0;
        bus_ack = 1'b0;
      end
      bus_rdata = $urandom;

      #1;
      chk1("r_stall", stall_req, (mem_req & ~e_mem_ack) | (if_req & ~e_if_ack & ~flush));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
